sdiv_s8by4: RTL and testbench
=============================

SDIV_S8BY4 -- requirements
Module: sdiv_s8by4

Interface
REQ-001 Parameters SHALL be none; widths fixed at 8-bit dividend, 4-bit divisor, 8-bit quotient, 4-bit remainder.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request; sampled only while idle.
REQ-005 a  input  8  signed two's-complement dividend.
REQ-006 b  input  4  signed two's-complement divisor.
REQ-007 busy  output  1  high while a division is in progress.
REQ-008 done  output  1  one-cycle pulse marking quotient/remainder/flags valid.
REQ-009 quot  output  8  signed quotient.
REQ-010 rem  output  4  signed remainder.
REQ-011 ovf  output  1  quotient overflow flag.
REQ-012 dbz  output  1  divide-by-zero flag.

Function
REQ-013 States SHALL be IDLE, CALC, FIX; busy = (state != IDLE).
REQ-014 IDLE with start=1 at edge k: capture |a| (8-bit unsigned), |b| (4-bit unsigned), sign(a), sign(b); go to CALC; iteration counter = 7.
REQ-015 CALC: one restoring shift-subtract step per cycle, MSB first, on magnitudes; partial remainder 5 bits; after the counter-0 step, go to FIX (8 CALC cycles).
REQ-016 FIX: apply signs and register quot, rem, ovf, dbz; set done=1; return to IDLE; done is high for exactly the cycle after edge k+9.
REQ-017 Rounding SHALL be truncation toward zero: sign(quot) = sign(a) XOR sign(b) (zero quotient is +0); sign(rem) = sign(a); |rem| < |b|; a == quot*b + rem.
REQ-018 a = -128, b = -1: ovf=1, quot=8'h80, rem=0; ovf=0 for every other operand pair.
REQ-019 start while busy SHALL be ignored; operands are not re-sampled.
REQ-020 start in the cycle done is high (state IDLE) SHALL be accepted; back-to-back issue every 10 cycles.
REQ-021 quot, rem, ovf, dbz SHALL hold their values until the next FIX; they change only in FIX.
REQ-022 a, b may change freely after capture without affecting the result.

Reset
REQ-023 rst=1 SHALL force state=IDLE, busy=0, done=0, quot=0, rem=0, ovf=0, dbz=0, counter=0, immediately and independent of clk.
REQ-024 Reset during CALC/FIX SHALL abort the operation; no done pulse is produced for it.
REQ-025 First start SHALL be accepted on the first rising edge with rst=0.

Configuration
REQ-026 Macro SDIV_DBZ_DET_EN defined: b=0 sampled in IDLE goes straight to FIX (done on the cycle after edge k+1), dbz=1, quot=0, rem=0, ovf=0.
REQ-027 SDIV_DBZ_DET_EN undefined: dbz tied 0; b=0 runs the normal 10-cycle path; quot/rem are don't-care but done timing is as in REQ-016.

Structure
REQ-028 Shared package sdiv_pkg SHALL hold the state enum (IDLE, CALC, FIX) and constants DVD_W=8, DVS_W=4, ITER=8.
REQ-029 One sub-module sdiv_step (combinational single restoring iteration: partial remainder in, divisor, next bit -> partial remainder out, quotient bit) is natural; control and sign logic stay in sdiv_s8by4.

Verification
REQ-030 a=100, b=7 -> quot=14, rem=2, ovf=0; done exactly 10 cycles after start edge.
REQ-031 a=-100, b=7 -> quot=-14, rem=-2; a=127, b=-8 -> quot=-15, rem=7; a=-128, b=1 -> quot=-128, rem=0.
REQ-032 a=-128, b=-1 -> ovf=1, quot=8'h80, rem=0.
REQ-033 Exhaustive sweep over all a in -128..127 and b != 0 (back-to-back starts) -> REQ-017 identity holds, ovf only per REQ-018.
REQ-034 start pulsed at cycle 4 of CALC with new operands -> ignored; result matches the first operands; rst asserted mid-CALC -> all outputs 0 immediately, no done.
REQ-035 b=0 with SDIV_DBZ_DET_EN -> dbz=1, quot=0, rem=0, done 2 cycles after start edge; without the macro -> dbz=0, done after 10 cycles.

Source files
------------

// File: rtl/sdiv_pkg.sv
// Shared types and constants for the signed 8-by-4 sequential divider.
package sdiv_pkg;

   localparam int unsigned DVD_W = 8;
   localparam int unsigned DVS_W = 4;
   localparam int unsigned ITER  = 8;
   localparam int unsigned PR_W  = DVS_W + 1;
   localparam int unsigned CNT_W = $clog2(ITER);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   // Magnitude of a two's-complement dividend; -128 maps to 128 (fits unsigned).
   function automatic logic [DVD_W-1:0] mag_dvd(input logic [DVD_W-1:0] v);
      return v[DVD_W-1] ? DVD_W'(~v + 1'b1) : v;
   endfunction

   // Magnitude of a two's-complement divisor; -8 maps to 8.
   function automatic logic [DVS_W-1:0] mag_dvs(input logic [DVS_W-1:0] v);
      return v[DVS_W-1] ? DVS_W'(~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/sdiv_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
module sdiv_step
   import sdiv_pkg::*;
(
   input  logic [PR_W-1:0]  i_pr,
   input  logic [DVS_W-1:0] i_dvs,
   input  logic             i_bit,
   output logic [PR_W-1:0]  o_pr,
   output logic             o_qbit
);

   localparam int unsigned WW = PR_W + 1;

   logic [WW-1:0] w_shift;

   // Shift in the next dividend bit; subtract the divisor when it fits.
   always_comb begin
      w_shift = {i_pr, i_bit};
      o_qbit  = (w_shift >= WW'(i_dvs));
      o_pr    = o_qbit ? PR_W'(w_shift - WW'(i_dvs)) : PR_W'(w_shift);
   end

endmodule

// File: rtl/sdiv_s8by4.sv
// Signed 8-bit by 4-bit sequential restoring divider, truncating toward zero.
// Optional divide-by-zero short-cut enabled by defining SDIV_DBZ_DET_EN.
module sdiv_s8by4
   import sdiv_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DVD_W-1:0] a,
   input  logic [DVS_W-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [DVD_W-1:0] quot,
   output logic [DVS_W-1:0] rem,
   output logic             ovf,
   output logic             dbz
);

   state_t             r_state;
   state_t             w_next;
   logic [CNT_W-1:0]   r_cnt;
   logic [DVD_W-1:0]   r_dvd;     // dividend bits shift out, quotient bits shift in
   logic [DVS_W-1:0]   r_dvs;
   logic [PR_W-1:0]    r_pr;
   logic               r_sa;
   logic               r_sb;
   logic               r_busy;
   logic               r_done;
   logic [DVD_W-1:0]   r_quot;
   logic [DVS_W-1:0]   r_rem;
   logic               r_ovf;
   logic               r_dbz;
`ifdef SDIV_DBZ_DET_EN
   logic               r_zero;
`endif

   logic [PR_W-1:0]    w_pr;
   logic               w_qbit;
   logic [DVD_W-1:0]   w_quot_s;
   logic [DVS_W-1:0]   w_rem_s;
   logic               w_ovf;

   sdiv_step u_step (
      .i_pr   (r_pr),
      .i_dvs  (r_dvs),
      .i_bit  (r_dvd[DVD_W-1]),
      .o_pr   (w_pr),
      .o_qbit (w_qbit)
   );

   // Sign fix-up: quotient takes sign(a)^sign(b), remainder takes sign(a).
   always_comb begin
      w_quot_s = (r_sa ^ r_sb) ? DVD_W'(~r_dvd + 1'b1) : r_dvd;
      w_rem_s  = r_sa ? DVS_W'(~r_pr[DVS_W-1:0] + 1'b1) : r_pr[DVS_W-1:0];
      w_ovf    = r_sa & r_sb & (r_dvs == DVS_W'(1)) & (r_dvd == DVD_W'(8'h80));
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (start) begin
`ifdef SDIV_DBZ_DET_EN
               w_next = (b == '0) ? FIX : CALC;
`else
               w_next = CALC;
`endif
            end
         end
         CALC:    if (r_cnt == '0) w_next = FIX;
         FIX:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Operand capture, iteration datapath and registered results.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= '0;
         r_dvd  <= '0;
         r_dvs  <= '0;
         r_pr   <= '0;
         r_sa   <= 1'b0;
         r_sb   <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_quot <= '0;
         r_rem  <= '0;
         r_ovf  <= 1'b0;
         r_dbz  <= 1'b0;
`ifdef SDIV_DBZ_DET_EN
         r_zero <= 1'b0;
`endif
      end else begin
         r_busy <= (w_next != IDLE);
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_dvd <= mag_dvd(a);
                  r_dvs <= mag_dvs(b);
                  r_sa  <= a[DVD_W-1];
                  r_sb  <= b[DVS_W-1];
                  r_pr  <= '0;
                  r_cnt <= CNT_W'(ITER - 1);
`ifdef SDIV_DBZ_DET_EN
                  r_zero <= (b == '0);
`endif
               end
            end
            CALC: begin
               r_dvd <= {r_dvd[DVD_W-2:0], w_qbit};
               r_pr  <= w_pr;
               r_cnt <= CNT_W'(r_cnt - 1'b1);
            end
            FIX: begin
               r_done <= 1'b1;
               r_quot <= w_quot_s;
               r_rem  <= w_rem_s;
               r_ovf  <= w_ovf;
               r_dbz  <= 1'b0;
`ifdef SDIV_DBZ_DET_EN
               if (r_zero) begin
                  r_quot <= '0;
                  r_rem  <= '0;
                  r_ovf  <= 1'b0;
                  r_dbz  <= 1'b1;
               end
`endif
            end
            default: ;
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign quot = r_quot;
   assign rem  = r_rem;
   assign ovf  = r_ovf;
   assign dbz  = r_dbz;

endmodule

// File: tb/tb_sdiv_s8by4.sv
// Self-checking bench for sdiv_s8by4 against an integer-arithmetic reference.
// Honours SDIV_DBZ_DET_EN for divide-by-zero expectations.
module tb_sdiv_s8by4;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a;
   logic [3:0] b;
   logic       busy, done, ovf, dbz;
   logic [7:0] quot;
   logic [3:0] rem;

   int checks = 0;
   int errors = 0;

   sdiv_s8by4 dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .quot  (quot),
      .rem   (rem),
      .ovf   (ovf),
      .dbz   (dbz)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one division at the current negedge; optional stray start at CALC cycle 4.
   task automatic run(input logic [7:0] ta, input logic [3:0] tb_, input bit glitch,
                      input bit full);
      int sa, sb, q, r, n, exp_lat;
      logic [7:0] eq;
      logic [3:0] er;
      logic       eovf, edbz, bsy1;
      sa = int'($signed(ta));
      sb = int'($signed(tb_));
      a = ta; b = tb_; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      a = 8'($urandom); b = 4'($urandom);
      n = 0; bsy1 = 1'b0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) bsy1 = busy;
         if (glitch && n == 4) begin
            start = 1'b1; a = 8'($urandom); b = 4'($urandom_range(1, 15));
         end
         if (glitch && n == 5) start = 1'b0;
      end while (!done && n < 20);
      edbz = 1'b0; eovf = 1'b0; eq = '0; er = '0; exp_lat = 10;
      if (sb == 0) begin
`ifdef SDIV_DBZ_DET_EN
         edbz = 1'b1; exp_lat = 2;
`endif
      end else begin
         q = sa / sb;
         r = sa % sb;
         eq = 8'(q);
         er = 4'(r);
         eovf = (q > 127);
      end
      if (full) chk("busy_after_start", 32'(bsy1), 32'd1);
      chk("latency", 32'(n), 32'(exp_lat));
      chk("dbz", 32'(dbz), 32'(edbz));
`ifndef SDIV_DBZ_DET_EN
      if (sb == 0) return;
`endif
      chk("quot", 32'(quot), 32'(eq));
      chk("rem", 32'(rem), 32'(er));
      chk("ovf", 32'(ovf), 32'(eovf));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_quot", 32'(quot), 32'd0);
      chk("rst_rem",  32'(rem),  32'd0);
      chk("rst_ovf",  32'(ovf),  32'd0);
      chk("rst_dbz",  32'(dbz),  32'd0);
      rst = 1'b0;

      // Directed cases, issued back-to-back.
      run(8'd100,               4'd7,               1'b0, 1'b1);
      run(8'($signed(-100)),    4'd7,               1'b0, 1'b1);
      run(8'd127,               4'($signed(-8)),    1'b0, 1'b1);
      run(8'h80,                4'd1,               1'b0, 1'b1);
      run(8'h80,                4'hF,               1'b0, 1'b1);
      run(8'd0,                 4'd5,               1'b0, 1'b1);
      run(8'd5,                 4'd0,               1'b0, 1'b1);
      run(8'($signed(-7)),      4'($signed(-3)),    1'b0, 1'b1);

      // done is a single-cycle pulse and results hold afterwards.
      @(negedge clk);
      chk("done_pulse_width", 32'(done), 32'd0);
      chk("hold_quot", 32'(quot), 32'(8'd2));
      chk("hold_rem",  32'(rem),  32'(4'hF));

      // Stray start during CALC is ignored.
      run(8'd100, 4'd7, 1'b1, 1'b1);

      // Reset mid-CALC aborts immediately and produces no done.
      a = 8'd77; b = 4'd3; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_quot", 32'(quot), 32'd0);
      chk("abort_rem",  32'(rem),  32'd0);
      chk("abort_ovf",  32'(ovf),  32'd0);
      @(negedge clk);
      rst = 1'b0;
      begin
         int seen = 0;
         for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) seen++;
         end
         chk("no_done_after_abort", 32'(seen), 32'd0);
      end

      // Randomized operands.
      for (int i = 0; i < 40; i++)
         run(8'($urandom), 4'($urandom), 1'b0, 1'b0);

      // Exhaustive sweep over nonzero divisors, back-to-back.
      for (int bi = -8; bi <= 7; bi++) begin
         if (bi == 0) continue;
         for (int ai = -128; ai <= 127; ai++)
            run(8'(ai), 4'(bi), 1'b0, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
